// File: rtl/wb_master_arbiter_pkg.sv
// Shared Wishbone bus types and arbiter constants for the two-master SoC bus.
// Imported by the arbiter top and its bus watchdog.
package wb_master_arbiter_pkg;

  typedef struct packed {
    logic        a_cyc;
    logic        a_stb;
    logic        a_we;
    logic [3:0]  a_sel;
    logic [31:0] a_adr;
    logic [31:0] a_dat;
  } wb_h2d_t;

  typedef struct packed {
    logic        d_ack;
    logic [31:0] d_dat;
  } wb_d2h_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_OWN0,
    ARB_OWN1
  } arb_state_t;

  localparam logic [31:0] WB_TIMEOUT_DATA   = 32'hDEAD_BEEF;
  localparam int          WB_TIMEOUT_CYCLES = 255;

  // Counter width able to hold 0..timeout inclusive.
  function automatic int wd_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/wb_master_arbiter_watchdog.sv
// Bus watchdog: counts strobe cycles left unacknowledged by the slave and
// raises a one-cycle termination pulse after TIMEOUT_CYCLES of them.
module wb_bus_watchdog
  import wb_master_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic cyc,
  input  logic stb,
  input  logic ack,
  output logic term
);

  localparam int            CW   = wd_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;
  logic          waiting;
  logic          expire;

  // The termination cycle itself never counts: the slave sees no strobe then.
  assign waiting = en & cyc & stb & ~ack & ~term;
  assign expire  = waiting & (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      term  <= 1'b0;
    end else begin
      term <= expire;
      if (!waiting || expire) count <= '0;
      else                    count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master round-robin Wishbone arbiter (CPU data port vs. UART SRAM loader)
// with burst-locked grants and a watchdog that error-terminates stalled cycles.
module wb_master_arbiter
  import wb_master_arbiter_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES,
  parameter logic [31:0] TIMEOUT_DATA   = WB_TIMEOUT_DATA
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  wb_h2d_t    m0_i,
  output wb_d2h_t    m0_o,
  input  wb_h2d_t    m1_i,
  output wb_d2h_t    m1_o,
  output wb_h2d_t    s_o,
  input  wb_d2h_t    s_i,
  output logic [1:0] grant_o,
  output logic       timeout_o
);

  arb_state_t state;
  logic [1:0] grant;
  logic       last_owner;
  wb_h2d_t    owner_req;
  logic       term;

  // Arbiter FSM: IDLE always separates two ownerships, so handoff costs one cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ARB_IDLE;
      grant      <= 2'b00;
      last_owner <= 1'b1;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (m0_i.a_cyc && (!m1_i.a_cyc || last_owner)) begin
            state <= ARB_OWN0;
            grant <= 2'b01;
          end else if (m1_i.a_cyc) begin
            state <= ARB_OWN1;
            grant <= 2'b10;
          end
        end
        ARB_OWN0: begin
          if (!m0_i.a_cyc) begin
            state      <= ARB_IDLE;
            grant      <= 2'b00;
            last_owner <= 1'b0;
          end
        end
        ARB_OWN1: begin
          if (!m1_i.a_cyc) begin
            state      <= ARB_IDLE;
            grant      <= 2'b00;
            last_owner <= 1'b1;
          end
        end
        default: begin
          state <= ARB_IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

  always_comb begin
    owner_req = '0;
    if (grant[0])      owner_req = m0_i;
    else if (grant[1]) owner_req = m1_i;
  end

  wb_bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk  (clk_i),
    .rst  (rst_i),
    .en   (state != ARB_IDLE),
    .cyc  (owner_req.a_cyc),
    .stb  (owner_req.a_stb),
    .ack  (s_i.d_ack),
    .term (term)
  );

  // Request/response muxes are combinational from the registered grant, so an
  // async reset releases the bus in the same cycle; a late ack during termination is dropped.
  always_comb begin
    s_o = owner_req;
    if (term) s_o.a_stb = 1'b0;

    m0_o = '0;
    m1_o = '0;
    if (grant[0]) begin
      m0_o = s_i;
      if (term) begin
        m0_o.d_ack = 1'b1;
        m0_o.d_dat = TIMEOUT_DATA;
      end
    end else if (grant[1]) begin
      m1_o = s_i;
      if (term) begin
        m1_o.d_ack = 1'b1;
        m1_o.d_dat = TIMEOUT_DATA;
      end
    end
  end

  assign grant_o   = grant;
  assign timeout_o = term;

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter: per-cycle vector table for arbitration,
// plus hand sequences for the watchdog boundaries and mid-cycle reset.
module tb_wb_master_arbiter;
  import wb_master_arbiter_pkg::*;

  localparam int          TO = 8;
  localparam logic [31:0] A0 = 32'h4000_0010;
  localparam logic [31:0] A1 = 32'h2000_0000;
  localparam logic [31:0] SD = 32'h1234_5678;

  logic       clk = 1'b0;
  logic       rst;
  wb_h2d_t    m0_i, m1_i, s_o;
  wb_d2h_t    m0_o, m1_o, s_i;
  logic [1:0] grant;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_master_arbiter #(
    .TIMEOUT_CYCLES(TO),
    .TIMEOUT_DATA  (32'hDEAD_BEEF)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .m0_i     (m0_i),
    .m0_o     (m0_o),
    .m1_i     (m1_i),
    .m1_o     (m1_o),
    .s_o      (s_o),
    .s_i      (s_i),
    .grant_o  (grant),
    .timeout_o(timeout)
  );

  typedef struct {
    logic        rst, c0, s0, c1, s1, ack;
    logic [1:0]  g;
    logic        sstb;
    logic [31:0] sadr;
    logic        a0, a1;
  } vec_t;

  vec_t tbl[24];

  function automatic vec_t mk(input logic r, c0, s0, c1, s1, ack,
                              input logic [1:0] g, input logic sstb,
                              input logic [31:0] sadr, input logic a0, a1);
    vec_t v;
    v.rst = r; v.c0 = c0; v.s0 = s0; v.c1 = c1; v.s1 = s1; v.ack = ack;
    v.g = g; v.sstb = sstb; v.sadr = sadr; v.a0 = a0; v.a1 = a1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic c0, s0, c1, s1, ack);
    m0_i = '0;
    m0_i.a_cyc = c0; m0_i.a_stb = s0; m0_i.a_we = 1'b1; m0_i.a_sel = 4'hF;
    if (c0) begin m0_i.a_adr = A0; m0_i.a_dat = 32'hA5A5_0000; end
    m1_i = '0;
    m1_i.a_cyc = c1; m1_i.a_stb = s1; m1_i.a_we = 1'b1; m1_i.a_sel = 4'hF;
    if (c1) begin m1_i.a_adr = A1; m1_i.a_dat = 32'h5A5A_0000; end
    s_i.d_ack = ack;
    s_i.d_dat = SD;
  endtask

  // m0 owns the bus with stb held; ack_at/term_at are 1-based stb cycles (0 = never).
  task automatic wd_xfer(input int ack_at, input int term_at, input bit late_ack, input string nm);
    bit done = 1'b0;
    for (int k = 1; k <= TO + 4 && !done; k++) begin
      @(posedge clk); #1;
      drive(1, 1, 0, 0, (k == ack_at) || (late_ack && k == term_at));
      @(negedge clk);
      if (k == term_at) begin
        chk($sformatf("%s term ack", nm), 32'(m0_o.d_ack), 32'd1);
        chk($sformatf("%s term dat", nm), m0_o.d_dat, 32'hDEAD_BEEF);
        chk($sformatf("%s term timeout", nm), 32'(timeout), 32'd1);
        chk($sformatf("%s term s_stb", nm), 32'(s_o.a_stb), 32'd0);
        chk($sformatf("%s term m1 ack", nm), 32'(m1_o.d_ack), 32'd0);
        done = 1'b1;
      end else if (k == ack_at) begin
        chk($sformatf("%s ack", nm), 32'(m0_o.d_ack), 32'd1);
        chk($sformatf("%s ack dat", nm), m0_o.d_dat, SD);
        chk($sformatf("%s ack timeout", nm), 32'(timeout), 32'd0);
        done = 1'b1;
      end else begin
        chk($sformatf("%s k%0d ack", nm, k), 32'(m0_o.d_ack), 32'd0);
        chk($sformatf("%s k%0d timeout", nm, k), 32'(timeout), 32'd0);
        chk($sformatf("%s k%0d s_stb", nm, k), 32'(s_o.a_stb), 32'd1);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

  initial begin
    //             rst c0 s0 c1 s1 ack grant  sstb sadr  a0 a1
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0, 0, 0);
    tbl[1]  = mk(0, 1, 1, 0, 0, 0, 2'b00, 0, 32'h0, 0, 0);
    tbl[2]  = mk(0, 1, 1, 0, 0, 0, 2'b01, 1, A0,    0, 0);
    tbl[3]  = mk(0, 1, 1, 0, 0, 0, 2'b01, 1, A0,    0, 0);
    tbl[4]  = mk(0, 1, 1, 0, 0, 0, 2'b01, 1, A0,    0, 0);
    tbl[5]  = mk(0, 1, 1, 0, 0, 1, 2'b01, 1, A0,    1, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 2'b01, 0, 32'h0, 0, 0);
    tbl[7]  = mk(1, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0, 0, 0);
    tbl[8]  = mk(0, 1, 1, 1, 1, 0, 2'b00, 0, 32'h0, 0, 0);
    tbl[9]  = mk(0, 1, 1, 1, 1, 1, 2'b01, 1, A0,    1, 0);
    tbl[10] = mk(0, 0, 0, 1, 1, 0, 2'b01, 0, 32'h0, 0, 0);
    tbl[11] = mk(0, 0, 0, 1, 1, 0, 2'b00, 0, 32'h0, 0, 0);
    tbl[12] = mk(0, 0, 0, 1, 1, 1, 2'b10, 1, A1,    0, 1);
    tbl[13] = mk(0, 1, 1, 0, 0, 0, 2'b10, 0, 32'h0, 0, 0);
    tbl[14] = mk(0, 1, 1, 1, 1, 0, 2'b00, 0, 32'h0, 0, 0);
    tbl[15] = mk(0, 1, 1, 1, 1, 1, 2'b01, 1, A0,    1, 0);
    tbl[16] = mk(0, 1, 1, 1, 1, 1, 2'b01, 1, A0,    1, 0);
    tbl[17] = mk(0, 1, 1, 1, 1, 1, 2'b01, 1, A0,    1, 0);
    tbl[18] = mk(0, 1, 1, 1, 1, 1, 2'b01, 1, A0,    1, 0);
    tbl[19] = mk(0, 0, 0, 1, 1, 0, 2'b01, 0, 32'h0, 0, 0);
    tbl[20] = mk(0, 0, 0, 1, 1, 0, 2'b00, 0, 32'h0, 0, 0);
    tbl[21] = mk(0, 0, 0, 1, 1, 0, 2'b10, 1, A1,    0, 0);
    tbl[22] = mk(0, 0, 0, 0, 0, 0, 2'b10, 0, 32'h0, 0, 0);
    tbl[23] = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0, 0, 0);

    rst = 1'b1;
    drive(1, 1, 1, 1, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset grant", 32'(grant), 32'd0);
    chk("reset timeout", 32'(timeout), 32'd0);
    chk("reset s_cyc", 32'(s_o.a_cyc), 32'd0);
    chk("reset s_adr", s_o.a_adr, 32'd0);
    chk("reset m0 ack", 32'(m0_o.d_ack), 32'd0);
    chk("reset m1 ack", 32'(m1_o.d_ack), 32'd0);

    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      rst = tbl[i].rst;
      drive(tbl[i].c0, tbl[i].s0, tbl[i].c1, tbl[i].s1, tbl[i].ack);
      @(negedge clk);
      chk($sformatf("r%0d grant", i), 32'(grant), 32'(tbl[i].g));
      chk($sformatf("r%0d s_stb", i), 32'(s_o.a_stb), 32'(tbl[i].sstb));
      chk($sformatf("r%0d s_adr", i), s_o.a_adr, tbl[i].sadr);
      chk($sformatf("r%0d m0 ack", i), 32'(m0_o.d_ack), 32'(tbl[i].a0));
      chk($sformatf("r%0d m1 ack", i), 32'(m1_o.d_ack), 32'(tbl[i].a1));
      chk($sformatf("r%0d timeout", i), 32'(timeout), 32'd0);
    end

    // Watchdog: m0 takes the bus, then stalled and near-boundary transfers.
    @(posedge clk); #1;
    drive(1, 1, 0, 0, 0);
    @(negedge clk);
    chk("wd setup grant", 32'(grant), 32'd0);
    wd_xfer(0, TO + 1, 1'b1, "t4a");
    wd_xfer(0, TO + 1, 1'b0, "t4b");
    wd_xfer(7, 0, 1'b0, "t5a");
    wd_xfer(TO, 0, 1'b0, "t5b");
    wd_xfer(0, TO + 1, 1'b0, "t5c");

    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("wd release grant", 32'(grant), 32'd1);

    // Reset in the middle of an m1 transfer, then a tie must go to m0.
    @(posedge clk); #1;
    drive(0, 0, 1, 1, 0);
    @(posedge clk); #1;
    drive(0, 0, 1, 1, 0);
    @(negedge clk);
    chk("t6 grant before", 32'(grant), 32'd2);
    chk("t6 s_stb before", 32'(s_o.a_stb), 32'd1);
    @(posedge clk); #1;
    drive(0, 0, 1, 1, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6 grant", 32'(grant), 32'd0);
    chk("t6 s_cyc", 32'(s_o.a_cyc), 32'd0);
    chk("t6 s_stb", 32'(s_o.a_stb), 32'd0);
    chk("t6 s_adr", s_o.a_adr, 32'd0);
    chk("t6 m1 ack", 32'(m1_o.d_ack), 32'd0);
    chk("t6 m1 dat", m1_o.d_dat, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1, 1, 1, 1, 0);
    @(negedge clk);
    chk("t6 idle grant", 32'(grant), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6 tie grant", 32'(grant), 32'd1);
    chk("t6 tie s_adr", s_o.a_adr, A0);
    chk("t6 tie m1 ack", 32'(m1_o.d_ack), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
